msk_round_ctrl: RTL

Sequencer for an iterated masked round datapath built from masked registers (one-cycle latency per register stage, no enable, no reset on shares). Accepts a load request, then steps the datapath through `NROUNDS` rounds of `LAT` register stages each. It advances only in cycles where fresh randomness is available, and hands the result off with a valid/ready handshake. The block drives only public control signals (load select, advance enable, round index). It never sees or touches shares.

---
 rtl/msk_ctrl_pkg.sv | 17 +
 rtl/msk_round_cnt.sv | 45 ++++
 rtl/msk_round_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/msk_ctrl_pkg.sv
// Shared types and helpers for the masked round sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package msk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a counter of n positions; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msk_round_cnt.sv
// Two-level stage/round counter stepping the masked datapath schedule.
// Latency: counters update one cycle after clr/inc; wrap is combinational from the registers.
// Backpressure: holds whenever inc is low; clr has priority over inc.
module msk_round_cnt
  import msk_ctrl_pkg::*;
#(
  parameter int NROUNDS = 12,
  parameter int LAT     = 1,
  parameter int RW      = clog2_min1(NROUNDS),
  parameter int SW      = clog2_min1(LAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] round,
  output logic [SW-1:0] stage,
  output logic          wrap
);

  logic stage_end;

  assign stage_end = (stage == SW'(LAT - 1));
  // Last stage of the last round: the next advance finishes the operation.
  assign wrap      = stage_end && (round == RW'(NROUNDS - 1));

  // Stage counts within a round; round steps on stage rollover and returns to 0 after the final round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round <= '0;
      stage <= '0;
    end else if (clr) begin
      round <= '0;
      stage <= '0;
    end else if (inc) begin
      if (stage_end) begin
        stage <= '0;
        round <= wrap ? '0 : round + RW'(1);
      end else begin
        stage <= stage + SW'(1);
      end
    end
  end

endmodule

// File: rtl/msk_round_ctrl.sv
// Sequencer for an iterated masked round datapath: load, NROUNDS*LAT advance steps, result handoff.
// Latency: RUN from the cycle after load; out_valid NROUNDS*LAT cycles later plus one per randomness stall.
// Backpressure: advances only when rnd_valid; DONE holds out_valid until out_ready; no load accepted while busy.
module msk_round_ctrl
  import msk_ctrl_pkg::*;
#(
  parameter int NROUNDS = 12,
  parameter int LAT     = 1,
  parameter int RW      = clog2_min1(NROUNDS),
  parameter int SW      = clog2_min1(LAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  output logic          dp_load,
  output logic          dp_en,
  output logic [RW-1:0] round,
  output logic [SW-1:0] stage,
  output logic          last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  state_t state, state_nxt;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   cnt_wrap;

  msk_round_cnt #(
    .NROUNDS(NROUNDS),
    .LAT    (LAT),
    .RW     (RW),
    .SW     (SW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .round(round),
    .stage(stage),
    .wrap (cnt_wrap)
  );

  // State register; reset forces IDLE immediately regardless of progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath mux selects; hold (both selects low) unless a state says otherwise.
  // dp_load is masked during reset so the datapath is never loaded while the controller is held.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    dp_load   = 1'b0;
    dp_en     = 1'b0;
    rnd_ready = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !rst) begin
          dp_load   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        rnd_ready = rnd_valid;
        dp_en     = rnd_valid;
        cnt_inc   = rnd_valid;
        if (rnd_valid && cnt_wrap) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign last      = (state == ST_RUN) && (round == RW'(NROUNDS - 1));

endmodule
